led_status_driver: RTL and testbench

- Produces the 10 active-high LED status bits for the board's LED bank. Its output feeds the LED polarity inverter directly.
- Converts short internal events into visible pulses:
  - hsync seen, vsync seen, pixel capture, and similar.
  - Events are stretched to a human-visible duration.
  - Adds a heartbeat blinker and a lock-status lamp.
- Lamp-test mode lights every LED for board bring-up.

---
 rtl/led_pkg.sv | 24 ++
 rtl/pulse_stretcher.sv | 62 ++++++
 rtl/led_status_driver.sv | 85 ++++++++
 tb/tb_led_status_driver.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants for the LED status bank: bit positions, channel
// counts and the counter-width helper used by the stretchers and the
// heartbeat divider.
package led_pkg;

  // Number of stretched event channels and total LED outputs.
  localparam int NUM_EVT  = 8;
  localparam int NUM_LEDS = 10;

  // Bit positions inside the LED output vector.
  localparam int LED_EVT_LSB   = 0;
  localparam int LED_LOCK      = 8;
  localparam int LED_HEARTBEAT = 9;

  // Width needed to hold values 0..max_value, never narrower than one bit
  // so a degenerate parameter still yields a legal vector.
  function automatic int count_width(input int max_value);
    if (max_value < 1) begin
      return 1;
    end
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// One event channel: detects a rising edge on its strobe and holds its
// "active" indication for STRETCH_CYCLES clocks, reloading on every new
// edge.  "active" reflects the counter value about to be registered, so
// the parent can register it without adding a cycle of latency.
module pulse_stretcher
  import led_pkg::*;
#(
  parameter int STRETCH_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic clear,
  output logic active
);

  localparam int            CW     = count_width(STRETCH_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(STRETCH_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic          prev;
  logic          rise;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // History starts high so an input already asserted at reset release is
  // treated as old news and produces no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b1;
    end else begin
      prev <= strobe;
    end
  end

  assign rise = strobe & ~prev;

  // Clear beats a new edge, a new edge beats the countdown, and the
  // countdown stops at zero instead of wrapping.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (rise) begin
      count_next = RELOAD;
    end else if (count != '0) begin
      count_next = count - ONE;
    end
  end

  // Stretch counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign active = (count_next != '0);

endmodule

// File: rtl/led_status_driver.sv
// LED status bank driver: eight stretched event lamps, a registered lock
// lamp and a free-running heartbeat, with a lamp-test override that
// lights everything.  All outputs are registered and active-high.
module led_status_driver
  import led_pkg::*;
#(
  parameter int STRETCH_CYCLES = 5000000,
  parameter int HEARTBEAT_HALF = 25000000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NUM_EVT-1:0]  i_events,
  input  logic                i_locked,
  input  logic                i_clear,
  input  logic                i_lamp_test,
  output logic [NUM_LEDS-1:0] o_ledbits
);

  localparam int              HB_W    = count_width(HEARTBEAT_HALF);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_HALF - 1);
  localparam logic [HB_W-1:0] HB_ONE  = HB_W'(1);

  logic [NUM_EVT-1:0]  evt_active;
  logic [HB_W-1:0]     hb_count;
  logic [HB_W-1:0]     hb_count_next;
  logic                hb_bit;
  logic                hb_bit_next;
  logic [NUM_LEDS-1:0] led_next;

  // One independent stretcher per event input.
  for (genvar n = 0; n < NUM_EVT; n++) begin : g_evt
    pulse_stretcher #(
      .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_stretch (
      .clk    (i_clk),
      .rst    (i_reset),
      .strobe (i_events[n]),
      .clear  (i_clear),
      .active (evt_active[n])
    );
  end

  // Heartbeat divider: count 0..HEARTBEAT_HALF-1 and flip the lamp on wrap.
  always_comb begin
    hb_count_next = hb_count + HB_ONE;
    hb_bit_next   = hb_bit;
    if (hb_count == HB_LAST) begin
      hb_count_next = '0;
      hb_bit_next   = ~hb_bit;
    end
  end

  // Heartbeat state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hb_count <= '0;
      hb_bit   <= 1'b0;
    end else begin
      hb_count <= hb_count_next;
      hb_bit   <= hb_bit_next;
    end
  end

  // Assemble the next LED word; lamp test overrides only the display, the
  // channels and heartbeat underneath keep running.
  always_comb begin
    led_next                         = '0;
    led_next[LED_EVT_LSB +: NUM_EVT] = evt_active;
    led_next[LED_LOCK]               = i_locked;
    led_next[LED_HEARTBEAT]          = hb_bit_next;
    if (i_lamp_test) begin
      led_next = '1;
    end
  end

  // Output register feeding the board's polarity inverter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ledbits <= '0;
    end else begin
      o_ledbits <= led_next;
    end
  end

endmodule

// File: tb/tb_led_status_driver.sv
// Directed bench for led_status_driver with STRETCH_CYCLES=4 and
// HEARTBEAT_HALF=3. Inputs change and outputs are sampled on the falling
// clock edge, midway between active edges.
module tb_led_status_driver;

  logic       clk;
  logic       reset;
  logic [7:0] events;
  logic       locked;
  logic       clear;
  logic       lamp_test;
  logic [9:0] ledbits;

  int vectors;
  int miscompares;

  led_status_driver #(
    .STRETCH_CYCLES(4),
    .HEARTBEAT_HALF(3)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_events    (events),
    .i_locked    (locked),
    .i_clear     (clear),
    .i_lamp_test (lamp_test),
    .o_ledbits   (ledbits)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive inputs, then let exactly one rising edge pass.
  task automatic applyStimulus(input logic [7:0] ev, input logic clr,
                               input logic lamp, input logic lock);
    events    = ev;
    clear     = clr;
    lamp_test = lamp;
    locked    = lock;
    @(negedge clk);
  endtask

  // Compare the masked LED word against the hand-computed value.
  task automatic checkOutput(input string tag, input logic [9:0] mask,
                             input logic [9:0] expected);
    vectors++;
    assert ((ledbits & mask) === (expected & mask)) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h (mask %h)",
             tag, ledbits & mask, expected & mask, mask);
    end
  endtask

  logic [9:0] hb_exp [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    hb_exp      = '{10'h000, 10'h000, 10'h200, 10'h200, 10'h200, 10'h000};

    // Reset with bit 0 already high: it must never light after release.
    reset     = 1'b1;
    events    = 8'h01;
    locked    = 1'b0;
    clear     = 1'b0;
    lamp_test = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_state", 10'h3FF, 10'h000);

    // Release; heartbeat sequence 0,0,1,1,1,0 and bit 0 stays dark.
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("heartbeat_%0d", i), 10'h3FF, hb_exp[i]);
    end

    // Drop bit 0, raise it again: one 4-cycle pulse, no repeat while held.
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("level_low", 10'h1FF, 10'h000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("level_pulse_%0d", i), 10'h1FF, 10'h001);
    end
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
    checkOutput("level_end", 10'h1FF, 10'h000);
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
    checkOutput("level_no_repulse", 10'h1FF, 10'h000);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);

    // Single one-cycle strobe on bit 2.
    applyStimulus(8'h04, 1'b0, 1'b0, 1'b0);
    checkOutput("single_0", 10'h1FF, 10'h004);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("single_%0d", i), 10'h1FF, 10'h004);
    end
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("single_end", 10'h1FF, 10'h000);

    // Retrigger bit 0 two cycles in: lit through k+5, dark at k+6.
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
    checkOutput("retrig_k0", 10'h1FF, 10'h001);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("retrig_k1", 10'h1FF, 10'h001);
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
    checkOutput("retrig_k2", 10'h1FF, 10'h001);
    for (int i = 3; i < 6; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("retrig_k%0d", i), 10'h1FF, 10'h001);
    end
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("retrig_end", 10'h1FF, 10'h000);

    // All channels fire together, then clear; clear also swallows an edge.
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    checkOutput("all_fire", 10'h1FF, 10'h0FF);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_all", 10'h1FF, 10'h000);
    applyStimulus(8'h08, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_vs_edge", 10'h1FF, 10'h000);
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b0);
    checkOutput("edge_dropped", 10'h1FF, 10'h000);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);

    // Lock lamp follows i_locked with one cycle of latency.
    locked = 1'b1;
    #1;
    checkOutput("lock_before_edge", 10'h100, 10'h000);
    @(negedge clk);
    checkOutput("lock_after_edge", 10'h1FF, 10'h100);

    // Lamp test lights everything while a channel keeps counting underneath.
    applyStimulus(8'h10, 1'b0, 1'b1, 1'b1);
    checkOutput("lamp_on", 10'h3FF, 10'h3FF);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("lamp_off", 10'h1FF, 10'h110);

    // Async reset in the middle of a pulse clears outputs before any edge.
    applyStimulus(8'h20, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_reset_pulse", 10'h1FF, 10'h130);
    events = 8'h00;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 10'h3FF, 10'h000);
    @(negedge clk);
    reset = 1'b0;

    // After release: pulse gone, lock back, heartbeat restarted from zero.
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("post_reset_1", 10'h3FF, 10'h100);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("post_reset_2", 10'h3FF, 10'h100);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("post_reset_3", 10'h3FF, 10'h300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
